ahb_arbiter: RTL and testbench
==============================

# ahb_arbiter

Multi-master AHB bus arbiter. It shares the single AHB address/data path between `NUM_MASTERS` requesters. It uses round-robin arbitration, holds ownership through fixed-length bursts and locked sequences, and tracks address-phase and data-phase ownership. Its outputs drive the master-side address/write-data muxes (`HMASTER`, `HMASTER_DATA`) that sit in front of the decoder and the slaves, including the default slave.

## Interface
Parameters:
- `NUM_MASTERS`, 4: number of requesting masters (2..8).
- `DEFAULT_MASTER`, 0: master granted when nobody requests.
- `MW`, `$clog2(NUM_MASTERS)`: master index width (derived).

Ports:
- `HCLK`  in  1  bus clock; all state updates on its rising edge.
- `HRESET`  in  1  reset; asynchronous, active-high.
- `HBUSREQ`  in  NUM_MASTERS  per-master bus request.
- `HLOCK`  in  NUM_MASTERS  per-master locked-transfer request.
- `HTRANS`  in  2  muxed HTRANS of the current address-phase owner.
- `HBURST`  in  3  muxed HBURST of the current address-phase owner.
- `HREADY`  in  1  muxed slave ready; a phase completes only when it is 1.
- `HRESP`  in  2  muxed slave response (OKAY=00, ERROR=01).
- `HGRANT`  out  NUM_MASTERS  one-hot grant to the next bus owner.
- `HMASTER`  out  MW  address-phase owner index; selects the address mux.
- `HMASTER_DATA`  out  MW  data-phase owner index; selects the write-data mux.
- `HMASTLOCK`  out  1  current address phase is locked.

## Operation
Reset values:
- `HGRANT` = one-hot(`DEFAULT_MASTER`).
- `HMASTER` = `HMASTER_DATA` = `DEFAULT_MASTER`.
- `HMASTLOCK` = 0.
- Round-robin pointer = `DEFAULT_MASTER`.
- Beat counter = 0.
- State = `ARB`.

Round-robin picker:
- Searches `HBUSREQ` starting at (pointer+1) mod `NUM_MASTERS`, wrapping around.
- Result is `DEFAULT_MASTER` if no bit is set.
- Pointer loads the picked index only when a real requester wins.

State machine (states `ARB`, `BURST`, `LOCKED`):
- `ARB`: on each edge with `HREADY`=1, `HGRANT` takes the picker result.
  - If the owner's `HTRANS`=NONSEQ with a fixed burst (INCR4/8/16, WRAP4/8/16, beats 4/8/16), load the counter with beats-1 and go to `BURST`.
  - If the granted master's `HLOCK`=1, go to `LOCKED`.
- `BURST`: `HGRANT` is frozen. The counter decrements on each edge with `HREADY`=1 and `HTRANS`=SEQ; BUSY and wait states do not decrement it.
  - When the counter is 1 and a SEQ is accepted, re-arbitrate on that edge and return to `ARB` (or to `LOCKED` if the owner's `HLOCK`=1).
- `LOCKED`: `HGRANT` is frozen while the owner's `HLOCK`=1. The block returns to `ARB` on the first `HREADY`=1 edge after `HLOCK` falls; that edge re-arbitrates.
- SINGLE and INCR (undefined length) stay in `ARB`. An INCR owner keeps the grant only by winning the picker.
  - Exception: while the owner's `HBUSREQ`=1 and `HTRANS`=SEQ/BUSY, `HGRANT` holds, so an INCR is never split mid-beat.

Ownership pipeline:
- `HMASTER` <= index(`HGRANT`) on every edge with `HREADY`=1.
- `HMASTER_DATA` <= `HMASTER` on every edge with `HREADY`=1.
- `HMASTLOCK` <= granted master's `HLOCK`, in step with `HMASTER`.

ERROR response (two cycles: `HREADY`=0, then `HREADY`=1 with `HRESP`=01):
- Clear the counter.
- Go to `ARB` on the second cycle's edge. That edge re-arbitrates, unless `LOCKED` and `HLOCK` is still 1.

## Timing
- Grant latency: a new request with the bus idle gives `HGRANT` at edge E+1, `HMASTER` at E+2 (with `HREADY`=1 throughout), and `HMASTER_DATA` at E+3.
- With `HREADY`=0, every output register holds its value.
- A request and another master's burst end on the same edge: the picker sees the current `HBUSREQ`, and round-robin order is respected.
- Reset asserted mid-burst: all outputs return to their reset values asynchronously and the counter is cleared.
- `HGRANT` is always exactly one-hot.

## Structure
- `ahb_params_pkg` holds:
  - HTRANS codes (IDLE/BUSY/NONSEQ/SEQ);
  - HBURST codes;
  - HRESP codes;
  - the `arb_state_t` enum {`ARB`, `BURST`, `LOCKED`};
  - a `burst_beats(hburst)` function returning 0 for SINGLE/INCR.
- Sub-module `ahb_rr_picker`: combinational, (requests, pointer) -> winner index plus a valid flag. It is reusable for the APB bridge queue.

## Test plan
- Reset with no requests -> `HGRANT`=0001, `HMASTER`=0, `HMASTLOCK`=0; all remain there.
- Masters 1 and 2 request continuously with SINGLE transfers -> grant alternates 1,2,1,2; `HMASTER_DATA` lags `HMASTER` by one `HREADY` cycle.
- M1 runs INCR8 with 2 BUSY cycles and 3 wait states while M3 requests -> `HGRANT` stays on M1 until the 8th beat is accepted, then moves to M3.
- M2 asserts `HLOCK` across two SINGLEs while M0 requests -> `HMASTLOCK`=1 for both transfers, and M0 is granted only after `HLOCK` drops.
- ERROR on beat 3 of M1's WRAP4 with M2 requesting -> M2 is granted on the second ERROR-cycle edge and the counter reads 0.
- Assert `HRESET` in the middle of a burst -> all outputs return immediately to their reset values; arbitration restarts from `DEFAULT_MASTER`.

Source files
------------

// File: rtl/ahb_params_pkg.sv
// Shared AHB encodings, arbiter state type and burst-length decode.
package ahb_params_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;
  localparam logic [1:0] HRESP_RETRY = 2'b10;
  localparam logic [1:0] HRESP_SPLIT = 2'b11;

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    BURST  = 2'd1,
    LOCKED = 2'd2
  } arb_state_t;

  // Fixed-length bursts only; SINGLE and INCR report 0.
  function automatic logic [4:0] burst_beats(input logic [2:0] hburst);
    case (hburst)
      HBURST_WRAP4,  HBURST_INCR4:  burst_beats = 5'd4;
      HBURST_WRAP8,  HBURST_INCR8:  burst_beats = 5'd8;
      HBURST_WRAP16, HBURST_INCR16: burst_beats = 5'd16;
      default:                      burst_beats = 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_arbiter_if.sv
// Arbiter-facing AHB signals: requests and muxed bus status in, grant and ownership out.
interface ahb_arbiter_if #(
  parameter int NUM_MASTERS = 4,
  parameter int MW          = $clog2(NUM_MASTERS)
);
  logic [NUM_MASTERS-1:0] HBUSREQ;
  logic [NUM_MASTERS-1:0] HLOCK;
  logic [1:0]             HTRANS;
  logic [2:0]             HBURST;
  logic                   HREADY;
  logic [1:0]             HRESP;
  logic [NUM_MASTERS-1:0] HGRANT;
  logic [MW-1:0]          HMASTER;
  logic [MW-1:0]          HMASTER_DATA;
  logic                   HMASTLOCK;

  // slave: the arbiter itself; master: the requesting side of the bus.
  modport slave (
    input  HBUSREQ, HLOCK, HTRANS, HBURST, HREADY, HRESP,
    output HGRANT, HMASTER, HMASTER_DATA, HMASTLOCK
  );

  modport master (
    output HBUSREQ, HLOCK, HTRANS, HBURST, HREADY, HRESP,
    input  HGRANT, HMASTER, HMASTER_DATA, HMASTLOCK
  );
endinterface

// File: rtl/ahb_rr_picker.sv
// Combinational round-robin picker: first set request after ptr, wrapping around.
module ahb_rr_picker #(
  parameter int N           = 4,
  parameter int DEFAULT_IDX = 0,
  parameter int W           = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] winner,
  output logic         valid
);
  localparam int unsigned NU = N;

  int unsigned idx;

  // Scan farthest-to-nearest so the nearest requester after ptr is written last.
  always_comb begin
    winner = W'(DEFAULT_IDX);
    valid  = 1'b0;
    idx    = 0;
    for (int unsigned i = NU; i >= 1; i--) begin
      idx = int'(ptr) + i;
      if (idx >= NU) idx = idx - NU;
      if (req[W'(idx)]) begin
        winner = W'(idx);
        valid  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/ahb_arbiter.sv
// Round-robin AHB arbiter with burst/lock hold and address/data-phase ownership tracking.
module ahb_arbiter
  import ahb_params_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0,
  parameter int MW             = $clog2(NUM_MASTERS)
) (
  input  logic         HCLK,
  input  logic         HRESET,
  ahb_arbiter_if.slave bus
);
  localparam logic [MW-1:0] DEF = MW'(DEFAULT_MASTER);

  arb_state_t    state_q, state_d;
  logic [MW-1:0] grant_q, grant_d, ptr_q, ptr_d;
  logic [MW-1:0] master_q, data_q, pick;
  logic [4:0]    cnt_q, cnt_d, beats;
  logic          pick_valid, lock_q, rearb, err, hold_incr, is_seq;

  ahb_rr_picker #(
    .N          (NUM_MASTERS),
    .DEFAULT_IDX(DEFAULT_MASTER),
    .W          (MW)
  ) u_picker (
    .req   (bus.HBUSREQ),
    .ptr   (ptr_q),
    .winner(pick),
    .valid (pick_valid)
  );

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    rearb     = 1'b0;
    beats     = burst_beats(bus.HBURST);
    err       = (bus.HRESP == HRESP_ERROR);
    is_seq    = (bus.HTRANS == HTRANS_SEQ);
    hold_incr = bus.HBUSREQ[master_q] &&
                (is_seq || bus.HTRANS == HTRANS_BUSY);
    if (err) cnt_d = '0;
    if (bus.HREADY) begin
      if (err) begin
        // An ERROR ends a burst but not a lock that is still being asserted.
        if (!(state_q == LOCKED && bus.HLOCK[grant_q])) begin
          rearb   = 1'b1;
          state_d = ARB;
        end
      end else begin
        case (state_q)
          ARB: begin
            if (!hold_incr) begin
              rearb = 1'b1;
              if (bus.HTRANS == HTRANS_NONSEQ && beats != 5'd0) begin
                state_d = BURST;
                cnt_d   = beats - 5'd1;
              end else if (bus.HLOCK[pick]) begin
                state_d = LOCKED;
              end
            end
          end
          BURST: begin
            if (is_seq) begin
              if (cnt_q == 5'd1) begin
                rearb   = 1'b1;
                cnt_d   = '0;
                state_d = bus.HLOCK[pick] ? LOCKED : ARB;
              end else begin
                cnt_d = cnt_q - 5'd1;
              end
            end
          end
          LOCKED: begin
            if (!bus.HLOCK[grant_q]) begin
              rearb   = 1'b1;
              state_d = ARB;
            end
          end
          default: state_d = ARB;
        endcase
      end
    end
    if (rearb) begin
      grant_d = pick;
      if (pick_valid) ptr_d = pick;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q  <= ARB;
      grant_q  <= DEF;
      ptr_q    <= DEF;
      cnt_q    <= '0;
      master_q <= DEF;
      data_q   <= DEF;
      lock_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      if (bus.HREADY) begin
        master_q <= grant_q;
        data_q   <= master_q;
        lock_q   <= bus.HLOCK[grant_q];
      end
    end
  end

  always_comb begin
    bus.HGRANT          = '0;
    bus.HGRANT[grant_q] = 1'b1;
  end

  assign bus.HMASTER      = master_q;
  assign bus.HMASTER_DATA = data_q;
  assign bus.HMASTLOCK    = lock_q;
endmodule

// File: tb/tb_ahb_arbiter.sv
// Scenario bench for ahb_arbiter: per-cycle expectations queued at drive time, checked after each edge.
module tb_ahb_arbiter;
  import ahb_params_pkg::*;

  localparam int N = 4;

  localparam logic [1:0] TI = HTRANS_IDLE;
  localparam logic [1:0] TB = HTRANS_BUSY;
  localparam logic [1:0] TN = HTRANS_NONSEQ;
  localparam logic [1:0] TS = HTRANS_SEQ;
  localparam logic [1:0] RO = HRESP_OKAY;
  localparam logic [1:0] RE = HRESP_ERROR;
  localparam logic [2:0] BS = HBURST_SINGLE;

  typedef struct packed {
    logic [3:0] req;
    logic [3:0] lock;
    logic [1:0] trans;
    logic [2:0] burst;
    logic       ready;
    logic [1:0] resp;
    logic [3:0] g;
    logic [1:0] hm;
    logic [1:0] hmd;
    logic       lk;
  } stim_t;

  logic HCLK = 1'b0;
  logic HRESET;
  int   checks = 0;
  int   fails  = 0;
  logic [8:0] sb[$];

  ahb_arbiter_if #(.NUM_MASTERS(N)) bus ();

  ahb_arbiter #(
    .NUM_MASTERS   (N),
    .DEFAULT_MASTER(0)
  ) dut (
    .HCLK  (HCLK),
    .HRESET(HRESET),
    .bus   (bus)
  );

  always #5 HCLK = ~HCLK;

  task automatic drive(input stim_t s);
    bus.HBUSREQ = s.req;
    bus.HLOCK   = s.lock;
    bus.HTRANS  = s.trans;
    bus.HBURST  = s.burst;
    bus.HREADY  = s.ready;
    bus.HRESP   = s.resp;
    sb.push_back({s.g, s.hm, s.hmd, s.lk});
  endtask

  task automatic drive_idle();
    bus.HBUSREQ = '0;
    bus.HLOCK   = '0;
    bus.HTRANS  = TI;
    bus.HBURST  = BS;
    bus.HREADY  = 1'b1;
    bus.HRESP   = RO;
  endtask

  task automatic apply_reset();
    HRESET = 1'b1;
    drive_idle();
    sb.delete();
    @(posedge HCLK);
    #1;
    HRESET = 1'b0;
  endtask

  task automatic test_reset();
    logic [8:0] e, got;
    stim_t t[3] = '{
      '{4'b0000, 4'b0000, TI, BS, 1'b1, RO, 4'b0001, 2'd0, 2'd0, 1'b0},
      '{4'b0000, 4'b0000, TI, BS, 1'b1, RO, 4'b0001, 2'd0, 2'd0, 1'b0},
      '{4'b0000, 4'b0000, TI, BS, 1'b1, RO, 4'b0001, 2'd0, 2'd0, 1'b0}
    };
    HRESET = 1'b1;
    drive_idle();
    #1;
    got = {bus.HGRANT, bus.HMASTER, bus.HMASTER_DATA, bus.HMASTLOCK};
    checks++;
    if (got !== 9'b0001_00_00_0) begin
      $display("FAIL reset_values: got %b, expected %b", got, 9'b0001_00_00_0);
      fails++;
    end
    @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    for (int s = 0; s < $size(t); s++) begin
      drive(t[s]);
      @(posedge HCLK);
      #1;
      e   = sb.pop_front();
      got = {bus.HGRANT, bus.HMASTER, bus.HMASTER_DATA, bus.HMASTLOCK};
      checks++;
      if (got !== e) begin
        $display("FAIL reset_idle step %0d: got g/hm/hmd/lk %b, expected %b", s, got, e);
        fails++;
      end
    end
  endtask

  task automatic test_singles();
    logic [8:0] e, got;
    stim_t t[10] = '{
      '{4'b0110, 4'b0000, TN, BS, 1'b1, RO, 4'b0010, 2'd0, 2'd0, 1'b0},
      '{4'b0110, 4'b0000, TN, BS, 1'b1, RO, 4'b0100, 2'd1, 2'd0, 1'b0},
      '{4'b0110, 4'b0000, TN, BS, 1'b1, RO, 4'b0010, 2'd2, 2'd1, 1'b0},
      '{4'b0110, 4'b0000, TN, BS, 1'b1, RO, 4'b0100, 2'd1, 2'd2, 1'b0},
      '{4'b0110, 4'b0000, TN, BS, 1'b1, RO, 4'b0010, 2'd2, 2'd1, 1'b0},
      '{4'b0110, 4'b0000, TN, BS, 1'b0, RO, 4'b0010, 2'd2, 2'd1, 1'b0},
      '{4'b0110, 4'b0000, TN, BS, 1'b0, RO, 4'b0010, 2'd2, 2'd1, 1'b0},
      '{4'b0000, 4'b0000, TI, BS, 1'b1, RO, 4'b0001, 2'd1, 2'd2, 1'b0},
      '{4'b0000, 4'b0000, TI, BS, 1'b1, RO, 4'b0001, 2'd0, 2'd1, 1'b0},
      '{4'b0000, 4'b0000, TI, BS, 1'b1, RO, 4'b0001, 2'd0, 2'd0, 1'b0}
    };
    apply_reset();
    for (int s = 0; s < $size(t); s++) begin
      drive(t[s]);
      @(posedge HCLK);
      #1;
      e   = sb.pop_front();
      got = {bus.HGRANT, bus.HMASTER, bus.HMASTER_DATA, bus.HMASTLOCK};
      checks++;
      if (got !== e) begin
        $display("FAIL singles step %0d: got g/hm/hmd/lk %b, expected %b", s, got, e);
        fails++;
      end
      checks++;
      if (!$onehot(bus.HGRANT)) begin
        $display("FAIL singles_onehot step %0d: got HGRANT %b, expected one-hot", s, bus.HGRANT);
        fails++;
      end
    end
  endtask

  task automatic test_burst();
    logic [8:0] e, got;
    stim_t t[17] = '{
      '{4'b0010, 4'b0000, TI, BS,           1'b1, RO, 4'b0010, 2'd0, 2'd0, 1'b0},
      '{4'b0010, 4'b0000, TI, BS,           1'b1, RO, 4'b0010, 2'd1, 2'd0, 1'b0},
      '{4'b0010, 4'b0000, TN, HBURST_INCR8, 1'b1, RO, 4'b0010, 2'd1, 2'd1, 1'b0},
      '{4'b1010, 4'b0000, TS, HBURST_INCR8, 1'b1, RO, 4'b0010, 2'd1, 2'd1, 1'b0},
      '{4'b1010, 4'b0000, TB, HBURST_INCR8, 1'b1, RO, 4'b0010, 2'd1, 2'd1, 1'b0},
      '{4'b1010, 4'b0000, TS, HBURST_INCR8, 1'b0, RO, 4'b0010, 2'd1, 2'd1, 1'b0},
      '{4'b1010, 4'b0000, TS, HBURST_INCR8, 1'b1, RO, 4'b0010, 2'd1, 2'd1, 1'b0},
      '{4'b1010, 4'b0000, TB, HBURST_INCR8, 1'b1, RO, 4'b0010, 2'd1, 2'd1, 1'b0},
      '{4'b1010, 4'b0000, TS, HBURST_INCR8, 1'b0, RO, 4'b0010, 2'd1, 2'd1, 1'b0},
      '{4'b1010, 4'b0000, TS, HBURST_INCR8, 1'b0, RO, 4'b0010, 2'd1, 2'd1, 1'b0},
      '{4'b1010, 4'b0000, TS, HBURST_INCR8, 1'b1, RO, 4'b0010, 2'd1, 2'd1, 1'b0},
      '{4'b1010, 4'b0000, TS, HBURST_INCR8, 1'b1, RO, 4'b0010, 2'd1, 2'd1, 1'b0},
      '{4'b1010, 4'b0000, TS, HBURST_INCR8, 1'b1, RO, 4'b0010, 2'd1, 2'd1, 1'b0},
      '{4'b1010, 4'b0000, TS, HBURST_INCR8, 1'b1, RO, 4'b0010, 2'd1, 2'd1, 1'b0},
      '{4'b1010, 4'b0000, TS, HBURST_INCR8, 1'b1, RO, 4'b1000, 2'd1, 2'd1, 1'b0},
      '{4'b1000, 4'b0000, TI, BS,           1'b1, RO, 4'b1000, 2'd3, 2'd1, 1'b0},
      '{4'b0000, 4'b0000, TI, BS,           1'b1, RO, 4'b0001, 2'd3, 2'd3, 1'b0}
    };
    apply_reset();
    for (int s = 0; s < $size(t); s++) begin
      drive(t[s]);
      @(posedge HCLK);
      #1;
      e   = sb.pop_front();
      got = {bus.HGRANT, bus.HMASTER, bus.HMASTER_DATA, bus.HMASTLOCK};
      checks++;
      if (got !== e) begin
        $display("FAIL incr8_burst step %0d: got g/hm/hmd/lk %b, expected %b", s, got, e);
        fails++;
      end
      checks++;
      if (!$onehot(bus.HGRANT)) begin
        $display("FAIL burst_onehot step %0d: got HGRANT %b, expected one-hot", s, bus.HGRANT);
        fails++;
      end
    end
  endtask

  task automatic test_locked();
    logic [8:0] e, got;
    stim_t t[7] = '{
      '{4'b0101, 4'b0100, TI, BS, 1'b1, RO, 4'b0100, 2'd0, 2'd0, 1'b0},
      '{4'b0101, 4'b0100, TI, BS, 1'b1, RO, 4'b0100, 2'd2, 2'd0, 1'b1},
      '{4'b0101, 4'b0100, TN, BS, 1'b1, RO, 4'b0100, 2'd2, 2'd2, 1'b1},
      '{4'b0101, 4'b0100, TN, BS, 1'b1, RO, 4'b0100, 2'd2, 2'd2, 1'b1},
      '{4'b0001, 4'b0000, TI, BS, 1'b0, RO, 4'b0100, 2'd2, 2'd2, 1'b1},
      '{4'b0001, 4'b0000, TI, BS, 1'b1, RO, 4'b0001, 2'd2, 2'd2, 1'b0},
      '{4'b0001, 4'b0000, TI, BS, 1'b1, RO, 4'b0001, 2'd0, 2'd2, 1'b0}
    };
    apply_reset();
    for (int s = 0; s < $size(t); s++) begin
      drive(t[s]);
      @(posedge HCLK);
      #1;
      e   = sb.pop_front();
      got = {bus.HGRANT, bus.HMASTER, bus.HMASTER_DATA, bus.HMASTLOCK};
      checks++;
      if (got !== e) begin
        $display("FAIL locked step %0d: got g/hm/hmd/lk %b, expected %b", s, got, e);
        fails++;
      end
    end
  endtask

  task automatic test_error();
    logic [8:0] e, got;
    stim_t t[7] = '{
      '{4'b0010, 4'b0000, TI, BS,           1'b1, RO, 4'b0010, 2'd0, 2'd0, 1'b0},
      '{4'b0010, 4'b0000, TI, BS,           1'b1, RO, 4'b0010, 2'd1, 2'd0, 1'b0},
      '{4'b0010, 4'b0000, TN, HBURST_WRAP4, 1'b1, RO, 4'b0010, 2'd1, 2'd1, 1'b0},
      '{4'b0110, 4'b0000, TS, HBURST_WRAP4, 1'b1, RO, 4'b0010, 2'd1, 2'd1, 1'b0},
      '{4'b0110, 4'b0000, TS, HBURST_WRAP4, 1'b0, RE, 4'b0010, 2'd1, 2'd1, 1'b0},
      '{4'b0110, 4'b0000, TI, HBURST_WRAP4, 1'b1, RE, 4'b0100, 2'd1, 2'd1, 1'b0},
      '{4'b0100, 4'b0000, TI, BS,           1'b1, RO, 4'b0100, 2'd2, 2'd1, 1'b0}
    };
    apply_reset();
    for (int s = 0; s < $size(t); s++) begin
      drive(t[s]);
      @(posedge HCLK);
      #1;
      e   = sb.pop_front();
      got = {bus.HGRANT, bus.HMASTER, bus.HMASTER_DATA, bus.HMASTLOCK};
      checks++;
      if (got !== e) begin
        $display("FAIL error_wrap4 step %0d: got g/hm/hmd/lk %b, expected %b", s, got, e);
        fails++;
      end
      if (s == 5) begin
        checks++;
        if (dut.cnt_q !== 5'd0) begin
          $display("FAIL error_counter: got %0d, expected 0", dut.cnt_q);
          fails++;
        end
        checks++;
        if (dut.state_q !== ARB) begin
          $display("FAIL error_state: got %0d, expected %0d", dut.state_q, ARB);
          fails++;
        end
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [8:0] e, got;
    stim_t pre[4] = '{
      '{4'b0010, 4'b0000, TI, BS,           1'b1, RO, 4'b0010, 2'd0, 2'd0, 1'b0},
      '{4'b0010, 4'b0000, TI, BS,           1'b1, RO, 4'b0010, 2'd1, 2'd0, 1'b0},
      '{4'b0010, 4'b0000, TN, HBURST_INCR4, 1'b1, RO, 4'b0010, 2'd1, 2'd1, 1'b0},
      '{4'b0010, 4'b0000, TS, HBURST_INCR4, 1'b1, RO, 4'b0010, 2'd1, 2'd1, 1'b0}
    };
    stim_t post[2] = '{
      '{4'b0110, 4'b0000, TI, BS, 1'b1, RO, 4'b0010, 2'd0, 2'd0, 1'b0},
      '{4'b0110, 4'b0000, TI, BS, 1'b1, RO, 4'b0100, 2'd1, 2'd0, 1'b0}
    };
    apply_reset();
    for (int s = 0; s < $size(pre); s++) begin
      drive(pre[s]);
      @(posedge HCLK);
      #1;
      e   = sb.pop_front();
      got = {bus.HGRANT, bus.HMASTER, bus.HMASTER_DATA, bus.HMASTLOCK};
      checks++;
      if (got !== e) begin
        $display("FAIL midreset_pre step %0d: got g/hm/hmd/lk %b, expected %b", s, got, e);
        fails++;
      end
    end
    #2;
    HRESET = 1'b1;
    #1;
    got = {bus.HGRANT, bus.HMASTER, bus.HMASTER_DATA, bus.HMASTLOCK};
    checks++;
    if (got !== 9'b0001_00_00_0) begin
      $display("FAIL midreset_async: got %b, expected %b", got, 9'b0001_00_00_0);
      fails++;
    end
    checks++;
    if (dut.cnt_q !== 5'd0) begin
      $display("FAIL midreset_counter: got %0d, expected 0", dut.cnt_q);
      fails++;
    end
    @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    for (int s = 0; s < $size(post); s++) begin
      drive(post[s]);
      @(posedge HCLK);
      #1;
      e   = sb.pop_front();
      got = {bus.HGRANT, bus.HMASTER, bus.HMASTER_DATA, bus.HMASTLOCK};
      checks++;
      if (got !== e) begin
        $display("FAIL midreset_restart step %0d: got g/hm/hmd/lk %b, expected %b", s, got, e);
        fails++;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    HRESET = 1'b1;
    drive_idle();
    @(posedge HCLK);
    #1;
    test_reset();
    test_singles();
    test_burst();
    test_locked();
    test_error();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
